multisim_stream_downsizer: RTL
==============================

# multisim_stream_downsizer

Width-converting stage placed directly downstream of the multisim pull client. It accepts DATA_WIDTH-bit words on a valid/ready stream and emits each word as RATIO consecutive OUT_WIDTH-bit beats to the DUT-side consumer, flagging the final beat. This lets a wide DPI transfer feed a narrow DUT interface without per-beat DPI calls. Back-to-back words stream at full output throughput.

## Interface

- DATA_WIDTH, 64: input word width; must equal RATIO*OUT_WIDTH (elaboration-time `$fatal` otherwise).
- OUT_WIDTH, 16: output beat width; ≥1.
- LSB_FIRST, 1: 1 emits bits [OUT_WIDTH-1:0] first; 0 emits the MS slice first.
- clk  in  1  clock; all logic on posedge.
- rst  in  1  reset, synchronous, active-high.
- in_data_vld  in  1  upstream word valid (from pull client `data_vld`).
- in_data_rdy  out  1  block accepts word this cycle (to pull client `data_rdy`).
- in_data  in  DATA_WIDTH  upstream word.
- out_data_vld  out  1  beat valid.
- out_data_rdy  in  1  consumer accepts beat.
- out_data  out  OUT_WIDTH  current beat.
- out_last  out  1  current beat is the word's final beat (index RATIO-1).

## Operation

- Derived: RATIO = DATA_WIDTH/OUT_WIDTH; IDX_W = max(1, $clog2(RATIO)).
- State: word register `buf` (DATA_WIDTH), beat index `idx` (IDX_W), `full` flag. Two states: EMPTY (full=0) and EMIT (full=1).
- Handshakes: input transfer = in_data_vld & in_data_rdy; output transfer = out_data_vld & out_data_rdy.
- in_data_rdy = !full | (out_data_vld & out_data_rdy & out_last). Combinational path out_data_rdy→in_data_rdy is intentional.
- out_data_vld = full. out_last = full & (idx == RATIO-1).
- out_data = slice idx of buf (LSB_FIRST=1: buf[idx*OUT_WIDTH +: OUT_WIDTH]; else slice RATIO-1-idx).
- EMPTY: input transfer → load buf, idx←0, go EMIT.
- EMIT, output transfer, not last: idx←idx+1.
- EMIT, output transfer on last beat: with simultaneous input transfer → load new word, idx←0, stay EMIT; else go EMPTY, idx←0.
- EMIT, no output transfer: hold buf, idx, out_data stable (valid never drops without handshake).
- RATIO=1: every beat is last; block behaves as a 1-deep pipeline register with full throughput.
- in_data is sampled only on input transfer; in_data_vld without rdy has no effect.

## Timing

- Reset (rst=1 at posedge): full←0, idx←0, buf←0. During and after reset: out_data_vld=0, out_last=0, out_data=0, in_data_rdy=1 (once rst deasserts; rdy is 0 while rst is high).
- Reset mid-word: remaining beats discarded; no partial output after reset.
- Latency: word accepted at cycle N → first beat valid at cycle N+1.
- Throughput: with out_data_rdy held 1, one beat per cycle, no bubble between words; RATIO cycles per word.
- Input accepted at most once per RATIO output transfers.
- Output stall: out_data, out_last, idx unchanged until handshake.

## Structure

- Package `multisim_stream_pkg`: function `ratio_f(DATA_WIDTH, OUT_WIDTH)` and `idx_w_f(ratio)`; shared by future upsizer stage.
- Single module; no sub-module. Slice mux is a function inside the module.

## Test plan

- Single word: DATA_WIDTH=64, OUT_WIDTH=16, LSB_FIRST=1, in_data=64'h4444_3333_2222_1111, out_rdy=1 → beats 16'h1111, 2222, 3333, 4444 on cycles N+1..N+4, out_last only on 16'h4444, then vld=0.
- Back-to-back: two words presented continuously, out_rdy=1 → 8 consecutive valid beats, in_data_rdy=1 exactly on the cycle of first word's last beat, no gap.
- Backpressure: out_rdy toggled 1,0,0,1,... → each beat held stable while stalled, order preserved, no beat duplicated or dropped; in_data_rdy=0 throughout EMIT except last-beat handshake.
- MSB order: LSB_FIRST=0, same word → beats 16'h4444, 3333, 2222, 1111.
- Reset mid-word: assert rst after second beat → next cycle out_data_vld=0, in_data_rdy=0 while rst high, 1 after; new word restarts at beat 0.
- RATIO=1 (OUT_WIDTH=64): random stream with random out_rdy → output equals input sequence, every beat out_last=1, full throughput.

Source files
------------

// File: rtl/multisim_stream_pkg.sv
// Shared sizing helpers for the multisim stream width converters.
package multisim_stream_pkg;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_EMIT  = 1'b1
    } ds_state_e;

    function automatic int ratio_f(input int data_width, input int out_width);
        return (out_width > 0) ? data_width / out_width : 0;
    endfunction

    // Beat index needs at least one bit even when a word is a single beat.
    function automatic int idx_w_f(input int ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

endpackage

// File: rtl/multisim_stream_downsizer.sv
// Splits each DATA_WIDTH word from the pull client into RATIO OUT_WIDTH beats,
// flagging the final beat; back-to-back words stream without bubbles.
//
// state    | meaning
// ---------+-----------------------------------------------
// ST_EMPTY | no word held, upstream ready
// ST_EMIT  | word held, presenting beat r_idx downstream
module multisim_stream_downsizer
    import multisim_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int OUT_WIDTH  = 16,
    parameter int LSB_FIRST  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_data_vld,
    output logic                  in_data_rdy,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_data_vld,
    input  logic                  out_data_rdy,
    output logic [OUT_WIDTH-1:0]  out_data,
    output logic                  out_last
);

    localparam int RATIO = ratio_f(DATA_WIDTH, OUT_WIDTH);
    localparam int IDX_W = idx_w_f(RATIO);

    if (OUT_WIDTH < 1 || DATA_WIDTH != RATIO * OUT_WIDTH) begin : g_bad_width
        $fatal(1, "multisim_stream_downsizer: DATA_WIDTH must equal RATIO*OUT_WIDTH");
    end

    ds_state_e             r_state;
    logic [IDX_W-1:0]      r_idx;
    logic [DATA_WIDTH-1:0] r_buf;

    logic w_full;
    logic w_last;
    logic w_in_xfer;
    logic w_out_xfer;

    function automatic logic [OUT_WIDTH-1:0] slice_f(
        input logic [DATA_WIDTH-1:0] word,
        input logic [IDX_W-1:0]      idx
    );
        int sel;
        sel = (LSB_FIRST != 0) ? int'(idx) : (RATIO - 1 - int'(idx));
        return word[sel*OUT_WIDTH +: OUT_WIDTH];
    endfunction

    assign w_full     = (r_state == ST_EMIT);
    assign w_last     = w_full && (r_idx == IDX_W'(RATIO - 1));
    assign w_out_xfer = w_full && out_data_rdy;
    // Ready is held low during reset so the pull client never hands over a word that is then lost.
    assign in_data_rdy = !rst && (!w_full || (w_out_xfer && w_last));
    assign w_in_xfer   = in_data_vld && in_data_rdy;

    assign out_data_vld = w_full;
    assign out_last     = w_last;
    assign out_data     = slice_f(r_buf, r_idx);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_EMPTY;
            r_idx   <= '0;
            r_buf   <= '0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_in_xfer) begin
                        r_buf   <= in_data;
                        r_idx   <= '0;
                        r_state <= ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    if (w_out_xfer) begin
                        if (w_last) begin
                            r_idx <= '0;
                            if (w_in_xfer) begin
                                r_buf <= in_data;
                            end else begin
                                r_state <= ST_EMPTY;
                            end
                        end else begin
                            r_idx <= r_idx + IDX_W'(1);
                        end
                    end
                end
                default: r_state <= ST_EMPTY;
            endcase
        end
    end

endmodule
